// File: rtl/stream_fork_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : stream_fork_pkg
//  Purpose  : Shared types and helpers for the N-way buffered stream fork.
//  Revision : 1.0 - initial release
// ============================================================================
package stream_fork_pkg;

    // Fan-out policy: copy every beat everywhere, or follow the per-beat mask.
    typedef enum logic [0:0] {
        FORK_BROADCAST = 1'b0,
        FORK_MULTICAST = 1'b1
    } fork_mode_e;

    // Base bit offset of channel i inside the packed down_data bus.
    function automatic int chan_slice(input int i, input int width);
        return i * width;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ff_fifo_pow2_depth.sv
`default_nettype none
// ============================================================================
//  Module   : ff_fifo_pow2_depth
//  Purpose  : Flip-flop FIFO with 2**A_WIDTH entries and valid/ready ports.
//             A full FIFO still accepts a push when it is popped that cycle.
//  Revision : 1.0 - initial release
// ============================================================================
module ff_fifo_pow2_depth #(
    parameter int WIDTH   = 8,
    parameter int A_WIDTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] i_push_data,
    input  logic             i_push_valid,
    output logic             o_push_ready,
    output logic [WIDTH-1:0] o_pop_data,
    output logic             o_pop_valid,
    input  logic             i_pop_ready
);

    localparam int               c_DEPTH = 2 ** A_WIDTH;
    localparam logic [A_WIDTH:0] c_FULL  = (A_WIDTH + 1)'(c_DEPTH);

    logic [WIDTH-1:0]   r_mem [c_DEPTH];
    logic [A_WIDTH-1:0] r_wptr;
    logic [A_WIDTH-1:0] r_rptr;
    logic [A_WIDTH:0]   r_count;
    logic               w_push;
    logic               w_pop;

    assign o_pop_valid  = (r_count != '0);
    assign o_pop_data   = r_mem[r_rptr];
    // The pop frees the slot the push lands in, so full+pop can still push.
    assign o_push_ready = (r_count != c_FULL) | i_pop_ready;
    assign w_push       = i_push_valid & o_push_ready;
    assign w_pop        = o_pop_valid & i_pop_ready;

    // Pointer and occupancy bookkeeping; simultaneous push+pop keeps count.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + 1'b1;
            if (w_pop)  r_rptr <= r_rptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Payload storage; contents are meaningless until written, so no reset.
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wptr] <= i_push_data;
    end

endmodule
`default_nettype wire

// File: rtl/stream_fork_core.sv
`default_nettype none
// ============================================================================
//  Module   : stream_fork_core
//  Purpose  : Eager fork with per-channel sent mask. Each channel takes the
//             head beat once; the head pops when every selected channel has
//             it. Beats with an empty mask are dropped and counted.
//  Revision : 1.0 - initial release
// ============================================================================
module stream_fork_core #(
    parameter int N_OUT    = 2,
    parameter int D_WIDTH  = 6,
    parameter int DC_WIDTH = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [D_WIDTH-1:0]  i_head_data,
    input  logic [N_OUT-1:0]    i_head_mask,
    input  logic                i_head_valid,
    output logic                o_head_pop,
    output logic [D_WIDTH-1:0]  o_chan_data,
    output logic [N_OUT-1:0]    o_chan_valid,
    input  logic [N_OUT-1:0]    i_chan_ready,
    output logic [DC_WIDTH-1:0] o_drop_count
);

    logic [N_OUT-1:0]    r_sent;
    logic [N_OUT-1:0]    w_acc;
    logic                w_done;
    logic                w_drop;
    logic [DC_WIDTH-1:0] r_drop_count;

    // Offer the head only to selected channels that have not taken it yet.
    assign o_chan_valid = {N_OUT{i_head_valid}} & i_head_mask & ~r_sent;
    assign o_chan_data  = i_head_data;
    assign w_acc        = o_chan_valid & i_chan_ready;
    // Done when every channel is unselected, already served, or served now.
    assign w_done       = i_head_valid & (&(~i_head_mask | r_sent | w_acc));
    assign w_drop       = w_done & (i_head_mask == '0);
    assign o_head_pop   = w_done;
    assign o_drop_count = rst ? '0 : r_drop_count;

    // Remember which channels already own the head beat; clear on pop.
    always_ff @(posedge clk) begin
        if (rst || w_done) r_sent <= '0;
        else               r_sent <= r_sent | w_acc;
    end

    // Saturating count of beats discarded for having no destination.
    always_ff @(posedge clk) begin
        if (rst)                                 r_drop_count <= '0;
        else if (w_drop && (r_drop_count != '1)) r_drop_count <= r_drop_count + 1'b1;
    end

endmodule
`default_nettype wire

// File: rtl/stream_fork_nway.sv
`default_nettype none
// ============================================================================
//  Module   : stream_fork_nway
//  Purpose  : N-way buffered stream fork: input FIFO, eager fork core and one
//             output FIFO per downstream channel. Broadcast or masked
//             multicast, selected by MODE.
//  Revision : 1.0 - initial release
// ============================================================================
module stream_fork_nway
    import stream_fork_pkg::*;
#(
    parameter int D_WIDTH  = 6,
    parameter int A_WIDTH  = 2,
    parameter int N_OUT    = 2,
    parameter int MODE     = 0,
    parameter int DC_WIDTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [D_WIDTH-1:0]       up_data,
    input  logic [N_OUT-1:0]         up_mask,
    input  logic                     up_valid,
    output logic                     up_ready,
    output logic [N_OUT*D_WIDTH-1:0] down_data,
    output logic [N_OUT-1:0]         down_valid,
    input  logic [N_OUT-1:0]         down_ready,
    output logic [DC_WIDTH-1:0]      drop_count
);

    localparam int c_IN_WIDTH = D_WIDTH + N_OUT;

    logic                  w_in_ready;
    logic [c_IN_WIDTH-1:0] w_head_word;
    logic [D_WIDTH-1:0]    w_head_data;
    logic [N_OUT-1:0]      w_head_mask;
    logic                  w_head_valid;
    logic [N_OUT-1:0]      w_eff_mask;
    logic                  w_pop;
    logic [D_WIDTH-1:0]    w_fork_data;
    logic [N_OUT-1:0]      w_fork_valid;
    logic [N_OUT-1:0]      w_chan_ready;
    logic [N_OUT-1:0]      w_down_valid;

    // Nothing moves while reset is asserted.
    assign up_ready    = w_in_ready & ~rst;
    assign down_valid  = w_down_valid & {N_OUT{~rst}};
    assign {w_head_mask, w_head_data} = w_head_word;
    assign w_eff_mask  = (MODE == int'(FORK_BROADCAST)) ? '1 : w_head_mask;

    ff_fifo_pow2_depth #(
        .WIDTH   (c_IN_WIDTH),
        .A_WIDTH (A_WIDTH)
    ) u_in_fifo (
        .clk          (clk),
        .rst          (rst),
        .i_push_data  ({up_mask, up_data}),
        .i_push_valid (up_valid & ~rst),
        .o_push_ready (w_in_ready),
        .o_pop_data   (w_head_word),
        .o_pop_valid  (w_head_valid),
        .i_pop_ready  (w_pop)
    );

    stream_fork_core #(
        .N_OUT    (N_OUT),
        .D_WIDTH  (D_WIDTH),
        .DC_WIDTH (DC_WIDTH)
    ) u_core (
        .clk          (clk),
        .rst          (rst),
        .i_head_data  (w_head_data),
        .i_head_mask  (w_eff_mask),
        .i_head_valid (w_head_valid & ~rst),
        .o_head_pop   (w_pop),
        .o_chan_data  (w_fork_data),
        .o_chan_valid (w_fork_valid),
        .i_chan_ready (w_chan_ready),
        .o_drop_count (drop_count)
    );

    for (genvar g = 0; g < N_OUT; g++) begin : g_chan
        ff_fifo_pow2_depth #(
            .WIDTH   (D_WIDTH),
            .A_WIDTH (A_WIDTH)
        ) u_chan_fifo (
            .clk          (clk),
            .rst          (rst),
            .i_push_data  (w_fork_data),
            .i_push_valid (w_fork_valid[g]),
            .o_push_ready (w_chan_ready[g]),
            .o_pop_data   (down_data[chan_slice(g, D_WIDTH) +: D_WIDTH]),
            .o_pop_valid  (w_down_valid[g]),
            .i_pop_ready  (down_ready[g])
        );
    end

endmodule
`default_nettype wire

// File: tb/tb_stream_fork_nway.sv
`default_nettype none
// ============================================================================
//  Module   : tb_stream_fork_nway
//  Purpose  : Self-checking bench for stream_fork_nway: three instances
//             (broadcast, multicast, multicast with 2-bit drop counter)
//             share one stimulus bus; sel picks the active instance.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_stream_fork_nway;

    localparam int DW = 6;
    localparam int AW = 2;
    localparam int N  = 3;

    typedef logic [7:0] q8_t[$];
    typedef struct {logic [N-1:0] mask; logic [DW-1:0] data;} beat_t;
    typedef struct {logic [N-1:0] mask; logic [DW-1:0] data; logic [15:0] exp_drop;} drop_vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [DW-1:0] up_data    = '0;
    logic [N-1:0]  up_mask    = '0;
    logic          up_valid   = 1'b0;
    logic [N-1:0]  down_ready = '1;
    int            sel        = 0;

    logic v_b, v_m, v_s, ur_b, ur_m, ur_s;
    logic [N*DW-1:0] dd_b, dd_m, dd_s;
    logic [N-1:0]    dv_b, dv_m, dv_s;
    logic [15:0]     dc_b, dc_m;
    logic [1:0]      dc_s;

    assign v_b = up_valid && (sel == 0);
    assign v_m = up_valid && (sel == 1);
    assign v_s = up_valid && (sel == 2);

    stream_fork_nway #(.D_WIDTH(DW), .A_WIDTH(AW), .N_OUT(N), .MODE(0), .DC_WIDTH(16)) u_b (
        .clk(clk), .rst(rst), .up_data(up_data), .up_mask(up_mask), .up_valid(v_b), .up_ready(ur_b),
        .down_data(dd_b), .down_valid(dv_b), .down_ready(down_ready), .drop_count(dc_b));
    stream_fork_nway #(.D_WIDTH(DW), .A_WIDTH(AW), .N_OUT(N), .MODE(1), .DC_WIDTH(16)) u_m (
        .clk(clk), .rst(rst), .up_data(up_data), .up_mask(up_mask), .up_valid(v_m), .up_ready(ur_m),
        .down_data(dd_m), .down_valid(dv_m), .down_ready(down_ready), .drop_count(dc_m));
    stream_fork_nway #(.D_WIDTH(DW), .A_WIDTH(AW), .N_OUT(N), .MODE(1), .DC_WIDTH(2)) u_s (
        .clk(clk), .rst(rst), .up_data(up_data), .up_mask(up_mask), .up_valid(v_s), .up_ready(ur_s),
        .down_data(dd_s), .down_valid(dv_s), .down_ready(down_ready), .drop_count(dc_s));

    logic            cur_ready;
    logic [N*DW-1:0] cur_dd;
    logic [N-1:0]    cur_dv;
    logic [15:0]     cur_dc;

    // Route the selected instance's outputs to the checker.
    always_comb begin
        cur_ready = ur_b; cur_dd = dd_b; cur_dv = dv_b; cur_dc = dc_b;
        case (sel)
            1:       begin cur_ready = ur_m; cur_dd = dd_m; cur_dv = dv_m; cur_dc = dc_m; end
            2:       begin cur_ready = ur_s; cur_dd = dd_s; cur_dv = dv_s; cur_dc = {14'd0, dc_s}; end
            default: ;
        endcase
    end

    int  cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard state: received beats, expected beats from the reference model.
    q8_t rx [N];
    q8_t exp_q [N];
    int  first_acc, first_dv, acc_cnt, exp_drops;
    bit  any_dv;
    logic [N+DW-1:0] tx_q[$];

    int total = 0;
    int bad   = 0;

    // Monitor at the falling edge: downstream handshakes and the reference model
    // (each accepted beat is owed once to every channel in its effective mask).
    always @(negedge clk) begin
        if (!rst) begin
            logic [N-1:0] eff;
            for (int i = 0; i < N; i++) begin
                if (cur_dv[i] && down_ready[i]) begin
                    rx[i].push_back(8'(cur_dd[i*DW +: DW]));
                    if (first_dv < 0) first_dv = cyc;
                end
            end
            if (cur_dv != '0) any_dv = 1'b1;
            if (up_valid && cur_ready) begin
                acc_cnt++;
                if (first_acc < 0) first_acc = cyc;
                eff = (sel == 0) ? '1 : up_mask;
                for (int i = 0; i < N; i++) if (eff[i]) exp_q[i].push_back(8'(up_data));
                if (eff == '0) exp_drops++;
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic chk_q(input string name, input q8_t act, input q8_t req);
        int first_bad;
        first_bad = -1;
        for (int k = 0; k < req.size() && k < act.size(); k++)
            if (first_bad < 0 && act[k] !== req[k]) first_bad = k;
        total++;
        if (act.size() != req.size() || first_bad >= 0) begin
            bad++;
            $display("FAIL %s: actual size=%0d required size=%0d first differing index=%0d",
                     name, act.size(), req.size(), first_bad);
        end
    endtask

    task automatic clear_sb();
        for (int i = 0; i < N; i++) begin rx[i].delete(); exp_q[i].delete(); end
        first_acc = -1; first_dv = -1; acc_cnt = 0; exp_drops = 0; any_dv = 1'b0;
    endtask

    task automatic tick();
        @(negedge clk);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input string tag);
        rst = 1'b1; up_valid = 1'b0;
        #1;
        chk({tag, "_rst_up_ready"}, 32'(cur_ready), 0);
        chk({tag, "_rst_down_valid"}, 32'(cur_dv), 0);
        chk({tag, "_rst_drop"}, 32'(cur_dc), 0);
        tick();
        rst = 1'b0;
        #1;
        chk({tag, "_post_up_ready"}, 32'(cur_ready), 1);
        chk({tag, "_post_down_valid"}, 32'(cur_dv), 0);
        chk({tag, "_post_drop"}, 32'(cur_dc), 0);
        clear_sb();
    endtask

    // Present queued beats upstream; with rnd, valid and down_ready are randomized.
    task automatic drive(input int max_cycles, input bit rnd);
        bit hold, hs;
        hold = 1'b0;
        for (int k = 0; k < max_cycles; k++) begin
            if (tx_q.size() == 0) break;
            if (hold || !rnd || ($urandom_range(0, 1) == 1)) begin
                up_valid = 1'b1;
                {up_mask, up_data} = tx_q[0];
            end else begin
                up_valid = 1'b0;
            end
            if (rnd) down_ready = N'($urandom);
            @(negedge clk);
            hs = up_valid && cur_ready;
            @(posedge clk);
            #1;
            hold = up_valid && !hs;
            if (hs) void'(tx_q.pop_front());
        end
        up_valid = 1'b0;
    endtask

    initial begin
        beat_t     t3 [3];
        drop_vec_t t4 [5];
        q8_t       e, e2;

        t3[0] = '{mask: 3'b101, data: 6'h11};
        t3[1] = '{mask: 3'b010, data: 6'h22};
        t3[2] = '{mask: 3'b111, data: 6'h33};
        for (int k = 0; k < 5; k++)
            t4[k] = '{mask: 3'b000, data: 6'(k + 1), exp_drop: (k < 3) ? 16'(k + 1) : 16'd3};

        // Test 1: broadcast, three back-to-back beats, latency of the first beat.
        sel = 0;
        do_reset("t1");
        down_ready = '1;
        tx_q.push_back({3'b000, 6'h05});
        tx_q.push_back({3'b000, 6'h0A});
        tx_q.push_back({3'b000, 6'h15});
        drive(20, 1'b0);
        repeat (6) tick();
        e = '{8'h05, 8'h0A, 8'h15};
        for (int i = 0; i < N; i++) chk_q($sformatf("t1_ch%0d", i), rx[i], e);
        chk("t1_latency", 32'(first_dv - first_acc), 2);

        // Test 2: channel 1 stalled, stream 1..12, then release.
        do_reset("t2");
        down_ready = 3'b101;
        for (int k = 1; k <= 12; k++) tx_q.push_back({3'b000, 6'(k)});
        drive(30, 1'b0);
        chk("t2_accepted", 32'(acc_cnt), 8);
        chk("t2_up_ready_low", 32'(cur_ready), 0);
        e.delete();
        for (int k = 1; k <= 5; k++) e.push_back(8'(k));
        chk_q("t2_ch0_partial", rx[0], e);
        chk_q("t2_ch2_partial", rx[2], e);
        chk("t2_ch1_nothing", 32'(rx[1].size()), 0);
        down_ready = '1;
        drive(60, 1'b0);
        repeat (12) tick();
        e.delete();
        for (int k = 1; k <= 12; k++) e.push_back(8'(k));
        for (int i = 0; i < N; i++) chk_q($sformatf("t2_ch%0d_all", i), rx[i], e);

        // Test 3: multicast masks from a table.
        sel = 1;
        do_reset("t3");
        for (int k = 0; k < 3; k++) tx_q.push_back({t3[k].mask, t3[k].data});
        drive(20, 1'b0);
        repeat (6) tick();
        e  = '{8'h11, 8'h33};
        e2 = '{8'h22, 8'h33};
        chk_q("t3_ch0", rx[0], e);
        chk_q("t3_ch1", rx[1], e2);
        chk_q("t3_ch2", rx[2], e);

        // Test 4: zero-mask beats into a 2-bit saturating drop counter.
        sel = 2;
        do_reset("t4");
        for (int k = 0; k < 5; k++) begin
            tx_q.push_back({t4[k].mask, t4[k].data});
            drive(20, 1'b0);
            repeat (3) tick();
            chk($sformatf("t4_drop_%0d", k), 32'(cur_dc), 32'(t4[k].exp_drop));
        end
        chk("t4_no_down_valid", 32'(any_dv), 0);

        // Test 5: reset while channel 2 still holds a beat.
        sel = 0;
        do_reset("t5a");
        down_ready = 3'b011;
        tx_q.push_back({3'b000, 6'h2A});
        drive(20, 1'b0);
        repeat (3) tick();
        chk("t5_only_ch2_pending", 32'(cur_dv), 32'(3'b100));
        do_reset("t5b");
        down_ready = '1;
        tx_q.push_back({3'b000, 6'h07});
        drive(20, 1'b0);
        repeat (6) tick();
        e = '{8'h07};
        for (int i = 0; i < N; i++) chk_q($sformatf("t5_ch%0d", i), rx[i], e);

        // Test 6: 1000 random multicast beats with random valid/ready.
        sel = 1;
        do_reset("t6");
        for (int k = 0; k < 1000; k++) tx_q.push_back({3'($urandom_range(0, 7)), 6'($urandom)});
        drive(30000, 1'b1);
        chk("t6_all_sent", 32'(tx_q.size()), 0);
        tx_q.delete();
        down_ready = '1;
        repeat (20) tick();
        for (int i = 0; i < N; i++) chk_q($sformatf("t6_ch%0d", i), rx[i], exp_q[i]);
        chk("t6_drop_count", 32'(cur_dc), 32'(exp_drops));
        chk("t6_accepted", 32'(acc_cnt), 1000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
